// File: rtl/turn_controller.sv
// N-player artillery turn sequencer: keyboard decode, charge/fire handshake, damage and rotation.
// Optional per-turn forfeit timer is enabled by defining TURN_TIMEOUT_EN.
module turn_controller #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned PW          = $clog2(NUM_PLAYERS),
  parameter int unsigned HP_W        = 8,
  parameter int unsigned MAX_HP      = 100,
  parameter int unsigned MOVE_BUDGET = 16,
  parameter int unsigned ANGLE_W     = 7,
  parameter int unsigned ANGLE_MAX   = 90,
  parameter int unsigned POWER_W     = 8,
  parameter int unsigned POWER_MAX   = 255,
  parameter int unsigned TURN_CYCLES = 1000000
) (
  input  logic                        clock,
  input  logic                        rst_n,
  input  logic [6:0]                  keyboard_input,
  input  logic                        start,
  output logic                        shot_valid,
  input  logic                        shot_ready,
  output logic [PW-1:0]               shot_player,
  output logic [ANGLE_W-1:0]          shot_angle,
  output logic [POWER_W-1:0]          shot_power,
  input  logic                        impact_valid,
  input  logic                        impact_hit,
  input  logic [PW-1:0]               impact_target,
  input  logic [HP_W-1:0]             impact_damage,
  output logic [PW-1:0]               cur_player,
  output logic                        move_step,
  output logic                        move_dir,
  output logic [ANGLE_W-1:0]          angle,
  output logic [POWER_W-1:0]          power,
  output logic [NUM_PLAYERS*HP_W-1:0] hp_flat,
  output logic [2:0]                  state,
  output logic                        game_over,
  output logic [PW-1:0]               winner,
  output logic                        draw
);

  localparam int unsigned BW = $clog2(MOVE_BUDGET + 1);

  localparam logic [HP_W-1:0]    HpInit     = HP_W'(MAX_HP);
  localparam logic [ANGLE_W-1:0] AngleInit  = ANGLE_W'(ANGLE_MAX / 2);
  localparam logic [ANGLE_W-1:0] AngleMax   = ANGLE_W'(ANGLE_MAX);
  localparam logic [POWER_W-1:0] PowerMax   = POWER_W'(POWER_MAX);
  localparam logic [BW-1:0]      BudgetInit = BW'(MOVE_BUDGET);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StTurn   = 3'd1,
    StCharge = 3'd2,
    StFire   = 3'd3,
    StFlight = 3'd4,
    StHit    = 3'd5,
    StNext   = 3'd6,
    StEnd    = 3'd7
  } state_e;

  state_e               state_q;
  logic [PW-1:0]        cur_q;
  logic [BW-1:0]        budget_q;
  logic [POWER_W-1:0]   power_q;
  logic [HP_W-1:0]      hp_q    [NUM_PLAYERS];
  logic [ANGLE_W-1:0]   angle_q [NUM_PLAYERS];
  logic                 move_step_q, move_dir_q;
  logic                 shot_valid_q;
  logic [PW-1:0]        shot_player_q;
  logic [ANGLE_W-1:0]   shot_angle_q;
  logic [POWER_W-1:0]   shot_power_q;
  logic [PW-1:0]        tgt_q;
  logic [HP_W-1:0]      dmg_q;
  logic                 game_over_q, draw_q;
  logic [PW-1:0]        winner_q;

  // Keyboard decode: a command counts only when exactly one command bit is set.
  logic [4:0] cmd;
  logic [1:0] phase;
  logic       cmd_ok, key_pos, key_hold, key_neg;
  logic       kb_fwd, kb_bwd, kb_up, kb_dn, kb_cannon;

  assign cmd       = keyboard_input[6:2];
  assign phase     = keyboard_input[1:0];
  assign cmd_ok    = $onehot(cmd) && (phase != 2'b00);
  assign key_pos   = cmd_ok && (phase == 2'b01);
  assign key_hold  = cmd_ok && (phase == 2'b11);
  assign key_neg   = cmd_ok && (phase == 2'b10);
  assign kb_fwd    = cmd[4];
  assign kb_bwd    = cmd[3];
  assign kb_up     = cmd[2];
  assign kb_dn     = cmd[1];
  assign kb_cannon = cmd[0];

  logic timeout;
`ifdef TURN_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TURN_CYCLES + 1);
  logic [TW-1:0] timer_q;

  assign timeout = (timer_q == TW'(TURN_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!rst_n || !(state_q inside {StTurn, StCharge})) begin
      timer_q <= '0;
    end else if (!timeout) begin
      timer_q <= timer_q + TW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  logic [ANGLE_W-1:0]       cur_angle, ang_up, ang_dn;
  logic [NUM_PLAYERS-1:0]   alive;
  int unsigned              alive_cnt;
  logic [PW-1:0]            sole, next_p;
  logic                     found;

  always_comb begin
    cur_angle = '0;
    alive     = '0;
    alive_cnt = 0;
    sole      = '0;
    next_p    = cur_q;
    found     = 1'b0;
    hp_flat   = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (cur_q == PW'(i)) cur_angle = angle_q[i];
      hp_flat[i*HP_W +: HP_W] = hp_q[i];
      if (hp_q[i] != '0) begin
        alive[i]  = 1'b1;
        alive_cnt = alive_cnt + 1;
        sole      = PW'(i);
      end
    end
    // Round-robin search for the first survivor after the current player.
    for (int unsigned k = 1; k < NUM_PLAYERS; k++) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        if (!found && alive[i] && (i == (32'(cur_q) + k) % NUM_PLAYERS)) begin
          found  = 1'b1;
          next_p = PW'(i);
        end
      end
    end
    ang_up = (cur_angle >= AngleMax) ? AngleMax : cur_angle + ANGLE_W'(1);
    ang_dn = (cur_angle == '0) ? '0 : cur_angle - ANGLE_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cur_q         <= '0;
      budget_q      <= '0;
      power_q       <= '0;
      move_step_q   <= 1'b0;
      move_dir_q    <= 1'b0;
      shot_valid_q  <= 1'b0;
      shot_player_q <= '0;
      shot_angle_q  <= '0;
      shot_power_q  <= '0;
      tgt_q         <= '0;
      dmg_q         <= '0;
      game_over_q   <= 1'b0;
      winner_q      <= '0;
      draw_q        <= 1'b0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        hp_q[i]    <= HpInit;
        angle_q[i] <= AngleInit;
      end
    end else begin
      move_step_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StTurn;
            budget_q <= BudgetInit;
            power_q  <= '0;
          end
        end
        StTurn: begin
          if (timeout) begin
            state_q <= StNext;
            power_q <= '0;
          end else if (key_pos) begin
            if ((kb_fwd || kb_bwd) && (budget_q != '0)) begin
              move_step_q <= 1'b1;
              move_dir_q  <= kb_fwd;
              budget_q    <= budget_q - BW'(1);
            end
            if (kb_up || kb_dn) begin
              for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                if (cur_q == PW'(i)) angle_q[i] <= kb_up ? ang_up : ang_dn;
              end
            end
            if (kb_cannon) begin
              state_q <= StCharge;
              power_q <= '0;
            end
          end
        end
        StCharge: begin
          if (timeout) begin
            state_q <= StNext;
            power_q <= '0;
          end else if (key_hold && kb_cannon) begin
            if (power_q != PowerMax) power_q <= power_q + POWER_W'(1);
          end else if (key_neg && kb_cannon) begin
            state_q       <= StFire;
            shot_valid_q  <= 1'b1;
            shot_player_q <= cur_q;
            shot_angle_q  <= cur_angle;
            shot_power_q  <= power_q;
          end
        end
        StFire: begin
          if (shot_ready) begin
            state_q       <= StFlight;
            shot_valid_q  <= 1'b0;
            shot_player_q <= '0;
            shot_angle_q  <= '0;
            shot_power_q  <= '0;
          end
        end
        StFlight: begin
          if (impact_valid) begin
            if (impact_hit) begin
              state_q <= StHit;
              tgt_q   <= impact_target;
              dmg_q   <= impact_damage;
            end else begin
              state_q <= StNext;
            end
          end
        end
        StHit: begin
          // Out-of-range targets match no player, so the damage is dropped.
          for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            if (tgt_q == PW'(i)) hp_q[i] <= (hp_q[i] > dmg_q) ? hp_q[i] - dmg_q : '0;
          end
          state_q <= StNext;
        end
        StNext: begin
          if (alive_cnt == 0) begin
            state_q     <= StEnd;
            game_over_q <= 1'b1;
            draw_q      <= 1'b1;
          end else if (alive_cnt == 1) begin
            state_q     <= StEnd;
            game_over_q <= 1'b1;
            winner_q    <= sole;
          end else begin
            state_q  <= StTurn;
            cur_q    <= next_p;
            budget_q <= BudgetInit;
            power_q  <= '0;
          end
        end
        StEnd: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign shot_valid  = shot_valid_q;
  assign shot_player = shot_player_q;
  assign shot_angle  = shot_angle_q;
  assign shot_power  = shot_power_q;
  assign cur_player  = cur_q;
  assign move_step   = move_step_q;
  assign move_dir    = move_dir_q;
  assign angle       = cur_angle;
  assign power       = power_q;
  assign state       = state_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;
  assign draw        = draw_q;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: a 2-player table run, 3-player rotation, and a zero-HP draw.
module tb_turn_controller;

  localparam logic [4:0] CmdNone = 5'b00000;
  localparam logic [4:0] CmdFwd  = 5'b10000;
  localparam logic [4:0] CmdBwd  = 5'b01000;
  localparam logic [4:0] CmdUp   = 5'b00100;
  localparam logic [4:0] CmdDn   = 5'b00010;
  localparam logic [4:0] CmdHold = 5'b00001;

  logic       clock = 1'b0;
  logic       rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  logic [6:0] kb = '0;
  logic       start = 1'b0, shot_ready = 1'b0;
  logic       impact_valid = 1'b0, impact_hit = 1'b0;
  logic [1:0] impact_target = '0;
  logic [7:0] impact_damage = '0;

  // Instance a: 2 players
  logic       a_sv, a_step, a_dir, a_go, a_draw;
  logic [0:0] a_sp, a_cur, a_win;
  logic [6:0] a_sa, a_ang;
  logic [7:0] a_spw, a_pwr;
  logic [15:0] a_hp;
  logic [2:0] a_st;
  // Instance b: 3 players, short turn timeout when enabled
  logic       b_sv, b_step, b_dir, b_go, b_draw;
  logic [1:0] b_sp, b_cur, b_win;
  logic [6:0] b_sa, b_ang;
  logic [7:0] b_spw, b_pwr;
  logic [23:0] b_hp;
  logic [2:0] b_st;
  // Instance c: 2 players starting with zero HP
  logic       c_sv, c_step, c_dir, c_go, c_draw;
  logic [0:0] c_sp, c_cur, c_win;
  logic [6:0] c_sa, c_ang;
  logic [7:0] c_spw, c_pwr;
  logic [15:0] c_hp;
  logic [2:0] c_st;

  turn_controller #(.NUM_PLAYERS(2)) u_dut_a (
    .clock(clock), .rst_n(rst_a), .keyboard_input(kb), .start(start),
    .shot_valid(a_sv), .shot_ready(shot_ready), .shot_player(a_sp), .shot_angle(a_sa),
    .shot_power(a_spw), .impact_valid(impact_valid), .impact_hit(impact_hit),
    .impact_target(impact_target[0:0]), .impact_damage(impact_damage), .cur_player(a_cur),
    .move_step(a_step), .move_dir(a_dir), .angle(a_ang), .power(a_pwr), .hp_flat(a_hp),
    .state(a_st), .game_over(a_go), .winner(a_win), .draw(a_draw)
  );

  turn_controller #(.NUM_PLAYERS(3), .TURN_CYCLES(20)) u_dut_b (
    .clock(clock), .rst_n(rst_b), .keyboard_input(kb), .start(start),
    .shot_valid(b_sv), .shot_ready(shot_ready), .shot_player(b_sp), .shot_angle(b_sa),
    .shot_power(b_spw), .impact_valid(impact_valid), .impact_hit(impact_hit),
    .impact_target(impact_target), .impact_damage(impact_damage), .cur_player(b_cur),
    .move_step(b_step), .move_dir(b_dir), .angle(b_ang), .power(b_pwr), .hp_flat(b_hp),
    .state(b_st), .game_over(b_go), .winner(b_win), .draw(b_draw)
  );

  turn_controller #(.NUM_PLAYERS(2), .MAX_HP(0)) u_dut_c (
    .clock(clock), .rst_n(rst_c), .keyboard_input(kb), .start(start),
    .shot_valid(c_sv), .shot_ready(shot_ready), .shot_player(c_sp), .shot_angle(c_sa),
    .shot_power(c_spw), .impact_valid(impact_valid), .impact_hit(impact_hit),
    .impact_target(impact_target[0:0]), .impact_damage(impact_damage), .cur_player(c_cur),
    .move_step(c_step), .move_dir(c_dir), .angle(c_ang), .power(c_pwr), .hp_flat(c_hp),
    .state(c_st), .game_over(c_go), .winner(c_win), .draw(c_draw)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic key(input logic [4:0] c, input logic [1:0] ph);
    kb = {c, ph};
    tick();
  endtask

  task automatic fire(input int n_hold);
    key(CmdHold, 2'b01);
    repeat (n_hold) key(CmdHold, 2'b11);
    key(CmdHold, 2'b10);
    kb = '0;
  endtask

  task automatic launch();
    shot_ready = 1'b1;
    tick();
    shot_ready = 1'b0;
  endtask

  task automatic impact(input logic hit, input logic [1:0] tgt, input logic [7:0] dmg);
    impact_valid  = 1'b1;
    impact_hit    = hit;
    impact_target = tgt;
    impact_damage = dmg;
    tick();
    impact_valid  = 1'b0;
  endtask

  typedef struct {
    logic [6:0] kb;
    logic       step;
    logic       dir;
    logic [6:0] ang;
    logic [7:0] pwr;
    logic [2:0] st;
    logic       sv;
  } vec_t;

  vec_t vecs[19];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;
    logic sv_seen;

    vecs[0]  = '{{CmdFwd,  2'b01}, 1'b1, 1'b1, 7'd45, 8'd0, 3'd1, 1'b0};
    vecs[1]  = '{{CmdFwd,  2'b11}, 1'b0, 1'b1, 7'd45, 8'd0, 3'd1, 1'b0};
    vecs[2]  = '{{CmdFwd,  2'b10}, 1'b0, 1'b1, 7'd45, 8'd0, 3'd1, 1'b0};
    vecs[3]  = '{{CmdBwd,  2'b01}, 1'b1, 1'b0, 7'd45, 8'd0, 3'd1, 1'b0};
    vecs[4]  = '{{CmdNone, 2'b00}, 1'b0, 1'b0, 7'd45, 8'd0, 3'd1, 1'b0};
    vecs[5]  = '{{5'b11000, 2'b01}, 1'b0, 1'b0, 7'd45, 8'd0, 3'd1, 1'b0};
    vecs[6]  = '{{CmdUp,   2'b01}, 1'b0, 1'b0, 7'd46, 8'd0, 3'd1, 1'b0};
    vecs[7]  = '{{CmdUp,   2'b11}, 1'b0, 1'b0, 7'd46, 8'd0, 3'd1, 1'b0};
    vecs[8]  = '{{CmdDn,   2'b01}, 1'b0, 1'b0, 7'd45, 8'd0, 3'd1, 1'b0};
    vecs[9]  = '{{CmdDn,   2'b01}, 1'b0, 1'b0, 7'd44, 8'd0, 3'd1, 1'b0};
    vecs[10] = '{{CmdFwd,  2'b00}, 1'b0, 1'b0, 7'd44, 8'd0, 3'd1, 1'b0};
    vecs[11] = '{{CmdHold, 2'b01}, 1'b0, 1'b0, 7'd44, 8'd0, 3'd2, 1'b0};
    vecs[12] = '{{CmdHold, 2'b11}, 1'b0, 1'b0, 7'd44, 8'd1, 3'd2, 1'b0};
    vecs[13] = '{{CmdHold, 2'b11}, 1'b0, 1'b0, 7'd44, 8'd2, 3'd2, 1'b0};
    vecs[14] = '{{CmdFwd,  2'b01}, 1'b0, 1'b0, 7'd44, 8'd2, 3'd2, 1'b0};
    vecs[15] = '{{CmdUp,   2'b01}, 1'b0, 1'b0, 7'd44, 8'd2, 3'd2, 1'b0};
    vecs[16] = '{{CmdHold, 2'b11}, 1'b0, 1'b0, 7'd44, 8'd3, 3'd2, 1'b0};
    vecs[17] = '{{CmdHold, 2'b10}, 1'b0, 1'b0, 7'd44, 8'd3, 3'd3, 1'b1};
    vecs[18] = '{{CmdHold, 2'b11}, 1'b0, 1'b0, 7'd44, 8'd3, 3'd3, 1'b1};

    // ---- Instance a: reset values ----
    tick();
    tick();
    chk("rst_state", 32'(a_st), 32'd0);
    chk("rst_shot_valid", 32'(a_sv), 32'd0);
    chk("rst_cur", 32'(a_cur), 32'd0);
    chk("rst_angle", 32'(a_ang), 32'd45);
    chk("rst_hp", 32'(a_hp), 32'h6464);
    chk("rst_power", 32'(a_pwr), 32'd0);
    chk("rst_game_over", 32'(a_go), 32'd0);
    chk("rst_shot_power", 32'(a_spw), 32'd0);

    rst_a = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_turn", 32'(a_st), 32'd1);

    for (int i = 0; i < 19; i++) begin
      key(vecs[i].kb[6:2], vecs[i].kb[1:0]);
      chk($sformatf("vec%0d_step", i), 32'(a_step), 32'(vecs[i].step));
      chk($sformatf("vec%0d_dir", i), 32'(a_dir), 32'(vecs[i].dir));
      chk($sformatf("vec%0d_angle", i), 32'(a_ang), 32'(vecs[i].ang));
      chk($sformatf("vec%0d_power", i), 32'(a_pwr), 32'(vecs[i].pwr));
      chk($sformatf("vec%0d_state", i), 32'(a_st), 32'(vecs[i].st));
      chk($sformatf("vec%0d_shot_valid", i), 32'(a_sv), 32'(vecs[i].sv));
    end
    kb = '0;
    chk("shot0_power", 32'(a_spw), 32'd3);
    chk("shot0_angle", 32'(a_sa), 32'd44);
    chk("shot0_player", 32'(a_sp), 32'd0);

    // Stalled handshake; a stray impact in FIRE is ignored
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(a_sv), 32'd1);
      chk("stall_angle", 32'(a_sa), 32'd44);
    end
    impact(1'b1, 2'd0, 8'd50);
    chk("stray_impact_state", 32'(a_st), 32'd3);
    chk("stray_impact_hp", 32'(a_hp), 32'h6464);
    launch();
    chk("handshake_valid_drop", 32'(a_sv), 32'd0);
    chk("handshake_flight", 32'(a_st), 32'd4);
    chk("handshake_power_clr", 32'(a_spw), 32'd0);
    impact(1'b0, 2'd0, 8'd0);
    chk("miss_next", 32'(a_st), 32'd6);
    tick();
    chk("miss_turn", 32'(a_st), 32'd1);
    chk("miss_cur", 32'(a_cur), 32'd1);
    chk("p1_angle", 32'(a_ang), 32'd45);
    chk("p1_power", 32'(a_pwr), 32'd0);

    // Move budget: 17 posedges give 16 single-cycle pulses
    pulses = 0;
    for (int i = 0; i < 17; i++) begin
      key(CmdFwd, 2'b01);
      if (a_step) pulses++;
      key(CmdNone, 2'b00);
      if (a_step) pulses++;
    end
    chk("budget_pulses", 32'(pulses), 32'd16);
    chk("budget_dir", 32'(a_dir), 32'd1);

    repeat (50) key(CmdUp, 2'b01);
    chk("angle_sat_hi", 32'(a_ang), 32'd90);
    repeat (100) key(CmdDn, 2'b01);
    chk("angle_sat_lo", 32'(a_ang), 32'd0);

    fire(10);
    chk("fire10_state", 32'(a_st), 32'd3);
    chk("fire10_power", 32'(a_spw), 32'd10);
    chk("fire10_angle", 32'(a_sa), 32'd0);
    chk("fire10_player", 32'(a_sp), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fire10_stall_valid", 32'(a_sv), 32'd1);
      chk("fire10_stall_power", 32'(a_spw), 32'd10);
    end
    launch();
    chk("fire10_drop", 32'(a_sv), 32'd0);
    impact(1'b1, 2'd1, 8'd150);
    chk("hit_state", 32'(a_st), 32'd5);
    tick();
    chk("hit_next", 32'(a_st), 32'd6);
    chk("hit_hp", 32'(a_hp), 32'h0064);
    tick();
    chk("end_state", 32'(a_st), 32'd7);
    chk("end_game_over", 32'(a_go), 32'd1);
    chk("end_winner", 32'(a_win), 32'd0);
    chk("end_draw", 32'(a_draw), 32'd0);
    key(CmdHold, 2'b01);
    chk("end_holds", 32'(a_st), 32'd7);
    kb = '0;

    // Reset during a pending handshake
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    fire(1);
    chk("prerst_valid", 32'(a_sv), 32'd1);
    rst_a = 1'b0;
    tick();
    chk("midrst_state", 32'(a_st), 32'd0);
    chk("midrst_valid", 32'(a_sv), 32'd0);
    chk("midrst_game_over", 32'(a_go), 32'd0);

    // ---- Instance b: 3-player rotation ----
    rst_b = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b_rst_hp", 32'(b_hp), 32'h646464);
    fire(2);
    chk("b_shot_player", 32'(b_sp), 32'd0);
    launch();
    impact(1'b1, 2'd1, 8'd200);
    tick();
    tick();
    chk("b_kill_state", 32'(b_st), 32'd1);
    chk("b_skip_dead", 32'(b_cur), 32'd2);
    chk("b_kill_hp", 32'(b_hp), 32'h640064);
    fire(0);
    launch();
    impact(1'b0, 2'd0, 8'd0);
    tick();
    chk("b_wrap", 32'(b_cur), 32'd0);
    fire(0);
    launch();
    impact(1'b1, 2'd3, 8'd50);
    tick();
    tick();
    chk("b_oob_cur", 32'(b_cur), 32'd2);
    chk("b_oob_hp", 32'(b_hp), 32'h640064);

    // Turn timeout (or its absence)
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    sv_seen = 1'b0;
    repeat (19) begin
      tick();
      if (b_sv) sv_seen = 1'b1;
    end
    chk("to_before", 32'(b_st), 32'd1);
`ifdef TURN_TIMEOUT_EN
    tick();
    if (b_sv) sv_seen = 1'b1;
    chk("to_next", 32'(b_st), 32'd6);
    tick();
    chk("to_turn", 32'(b_st), 32'd1);
    chk("to_cur", 32'(b_cur), 32'd1);
`else
    tick();
    tick();
    chk("no_to_state", 32'(b_st), 32'd1);
    chk("no_to_cur", 32'(b_cur), 32'd0);
`endif
    chk("to_no_shot", 32'(sv_seen), 32'd0);
    rst_b = 1'b0;

    // ---- Instance c: no survivors gives a draw ----
    rst_c = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    fire(0);
    launch();
    impact(1'b0, 2'd0, 8'd0);
    tick();
    chk("c_state", 32'(c_st), 32'd7);
    chk("c_draw", 32'(c_draw), 32'd1);
    chk("c_game_over", 32'(c_go), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
